// File: rtl/if_pkg.sv
// Shared types and constants for the fetch-queue IF stage.
package if_pkg;

    localparam int FQ_XLEN = 32;
    localparam int FQ_ILEN = 32;

    localparam logic [FQ_XLEN-1:0] DEF_RESET_PC = 32'h2000;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] inst;
        logic               jump;
    } fq_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fq_fifo.sv
// Circular FIFO of fetch entries with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fq_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  fq_entry_t     i_data,
    input  logic          i_pop,
    output fq_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    fq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = i_push;
    assign w_doPop  = i_pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_tail <= r_tail + PW'(1);
            if (w_doPop)  r_head <= r_head + PW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries between head and tail are ever observed.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush && !rst) begin
            r_mem[r_tail] <= i_data;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    pushNeverFull: assert property (@(posedge clk) disable iff (rst)
        (w_doPush && !i_flush && !w_doPop) |-> (r_count < CW'(DEPTH)));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-limited IM issue into a DEPTH-entry fetch queue.
// Optional macro IF_FQ_BYPASS_EN presents a response arriving at an empty queue the same cycle.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int               XLEN     = FQ_XLEN,
    parameter int               ILEN     = FQ_ILEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = DEF_RESET_PC,
    localparam int              CW       = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] bpu_pc,
    input  logic [XLEN-1:0] bpu_next_pc,
    input  logic            bpu_next_jump,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] IM_r_addr,
    output logic            IM_r_en,
    input  logic [ILEN-1:0] IM_r_data,
    output logic [XLEN-1:0] IF_out_pc,
    output logic [ILEN-1:0] IF_out_inst,
    output logic            IF_out_jump,
    output logic            IF_valid,
    input  logic            DC_ready,
    output logic [CW-1:0]   fq_count
);

    logic [XLEN-1:0] r_pc;
    logic            r_inflightV;
    logic [XLEN-1:0] r_inflightPc;
    logic            r_inflightJump;

    logic [XLEN-1:0] w_addr;
    fq_entry_t       w_inEntry;
    fq_entry_t       w_fifoHead;
    fq_entry_t       w_outEntry;
    logic [CW-1:0]   w_fifoCount;
    logic            w_fifoEmpty;
    logic            w_bypass;
    logic            w_show;
    logic            w_ifValid;
    logic            w_popFire;
    logic            w_fifoPop;
    logic            w_push;
    logic [CW:0]     w_occ;
    logic            w_creditOk;
    logic            w_issue;

    assign w_addr      = redirect ? redirect_pc : r_pc;
    assign w_fifoEmpty = (w_fifoCount == '0);
    assign w_inEntry   = '{pc: r_inflightPc, inst: IM_r_data, jump: r_inflightJump};

`ifdef IF_FQ_BYPASS_EN
    assign w_bypass = w_fifoEmpty & r_inflightV & ~redirect & ~rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_show     = (~w_fifoEmpty | w_bypass) & ~rst;
    assign w_ifValid  = w_show & ~redirect;
    assign w_popFire  = w_ifValid & DC_ready;
    assign w_fifoPop  = w_popFire & ~w_fifoEmpty;
    // A bypassed entry taken by DC this cycle never enters the queue.
    assign w_push     = r_inflightV & ~redirect & ~(w_bypass & DC_ready);

    // Occupancy the queue will have once the in-flight response lands; a new
    // request is only safe if that still leaves room for its own response.
    assign w_occ      = {1'b0, w_fifoCount} + {{CW{1'b0}}, r_inflightV}
                        - {{CW{1'b0}}, w_popFire};
    assign w_creditOk = (w_occ < (CW+1)'(DEPTH));
    assign w_issue    = ~rst & (redirect | w_creditOk);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_inflightV    <= 1'b0;
            r_inflightPc   <= '0;
            r_inflightJump <= 1'b0;
        end else if (w_issue) begin
            r_pc           <= bpu_next_pc;
            r_inflightV    <= 1'b1;
            r_inflightPc   <= w_addr;
            r_inflightJump <= bpu_next_jump;
        end else begin
            r_inflightV    <= 1'b0;
        end
    end

    if_fq_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  (w_inEntry),
        .i_pop   (w_fifoPop),
        .o_head  (w_fifoHead),
        .o_count (w_fifoCount)
    );

    assign w_outEntry  = w_bypass ? w_inEntry : w_fifoHead;

    assign bpu_pc      = w_addr;
    assign IM_r_addr   = w_addr;
    assign IM_r_en     = w_issue;
    assign IF_valid    = w_ifValid;
    assign IF_out_pc   = w_show ? w_outEntry.pc   : '0;
    assign IF_out_inst = w_show ? w_outEntry.inst : '0;
    assign IF_out_jump = w_show ? w_outEntry.jump : 1'b0;
    assign fq_count    = w_fifoCount;

endmodule
